// File: rtl/ftc_pkg.sv
// Shared definitions for the fetch stages of the token pipeline: field widths,
// the mem_wen bit map, the sideband packet record and the stage-1 control states.
package ftc_pkg;

  localparam int NODE_W   = 16;
  localparam int GEN_W    = 12;
  localparam int OPR_W    = 32;
  localparam int MEMWEN_W = 2;

  // mem_wen bit 0 marks a program-load packet, bit 1 is the forwarded flag
  localparam int MEMWEN_PLOAD_BIT = 0;
  localparam int MEMWEN_FWD_BIT   = 1;

  // Sideband half of a FIFO entry; the PM word is stored beside it because
  // its width is a stage parameter
  typedef struct packed {
    logic [NODE_W-1:0] node;
    logic [GEN_W-1:0]  gen;
    logic [OPR_W-1:0]  opr0;
    logic [OPR_W-1:0]  opr1;
    logic              mem_wen1;
    logic              w_en_cex;
  } ftc_pkt_t;

  // Stage-1 control view, derived from the read-in-flight flag and occupancy
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_HOLD,
    ST_FULL
  } ctrl_state_e;

endpackage

// File: rtl/ftc1_pm.sv
// Program memory for fetch stage 1: 2^ADDR_W x DATA_W words, one write port
// and one synchronous read port with a single cycle of read latency. A read
// that coincides with a write to the same address returns the new word.
// Contents are deliberately not reset.
module ftc1_pm #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write port plus registered read with write-first bypass
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/ftc1_stage.sv
// Fetch stage 1: looks up the instruction word for each normal packet in the
// local program memory, then queues {sideband, word} in a small output FIFO
// toward the next stage. Program-load packets write the PM and are consumed.
// Optional macro FTC1_PERF_CNT_EN adds saturating forward/stall counters.
module ftc1_stage
  import ftc_pkg::*;
#(
  parameter int PM_ADDR_W  = 10,
  parameter int INST_W     = 32,
  parameter int OBUF_DEPTH = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NODE_W-1:0]   node_i,
  input  logic [GEN_W-1:0]    gen_i,
  input  logic [OPR_W-1:0]    opr0_i,
  input  logic [OPR_W-1:0]    opr1_i,
  input  logic [MEMWEN_W-1:0] mem_wen_i,
  input  logic                w_en_cex_i,
  input  logic                send_i,
  output logic                ack_o,
  output logic [NODE_W-1:0]   node_o,
  output logic [GEN_W-1:0]    gen_o,
  output logic [OPR_W-1:0]    opr0_o,
  output logic [OPR_W-1:0]    opr1_o,
  output logic [INST_W-1:0]   inst_o,
  output logic                mem_wen1_o,
  output logic                w_en_cex_o,
  output logic                send_o,
  input  logic                ack_i
`ifdef FTC1_PERF_CNT_EN
  ,
  output logic [15:0]         perf_fwd_o,
  output logic [15:0]         perf_stall_o
`endif
);

  localparam int PTR_W = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(OBUF_DEPTH + 1);

  ftc_pkt_t          pkt_in;
  ftc_pkt_t          hold_q;
  ftc_pkt_t          head_pkt;
  logic              f_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  ftc_pkt_t          fifo_pkt  [OBUF_DEPTH];
  logic [INST_W-1:0] fifo_inst [OBUF_DEPTH];
  logic [INST_W-1:0] pm_rdata;
  ctrl_state_e       state;
  logic              accept;
  logic              is_load;
  logic              is_read;
  logic              push;
  logic              pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OBUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pkt_in = '{node:     node_i,
                    gen:      gen_i,
                    opr0:     opr0_i,
                    opr1:     opr1_i,
                    mem_wen1: mem_wen_i[MEMWEN_FWD_BIT],
                    w_en_cex: w_en_cex_i};

  // Control state seen from registers only; FULL counts the in-flight read so
  // a slot is always reserved for it and ack_i never reaches ack_o
  always_comb begin
    state = ST_IDLE;
    if ((int'(cnt_q) + int'(f_q)) >= OBUF_DEPTH) begin
      state = ST_FULL;
    end else if (f_q) begin
      state = ST_FILL;
    end else if (cnt_q != '0) begin
      state = ST_HOLD;
    end
  end

  assign ack_o   = (state != ST_FULL);
  assign accept  = send_i && ack_o;
  assign is_load = accept && mem_wen_i[MEMWEN_PLOAD_BIT];
  assign is_read = accept && !mem_wen_i[MEMWEN_PLOAD_BIT];
  assign push    = f_q;
  assign send_o  = (cnt_q != '0);
  assign pop     = send_o && ack_i;

  ftc1_pm #(
    .ADDR_W (PM_ADDR_W),
    .DATA_W (INST_W)
  ) u_pm (
    .clk   (clk),
    .we    (is_load),
    .waddr (opr0_i[PM_ADDR_W-1:0]),
    .wdata (opr1_i[INST_W-1:0]),
    .re    (is_read),
    .raddr (node_i[PM_ADDR_W-1:0]),
    .rdata (pm_rdata)
  );

  // Read-in-flight flag, sideband holding register, FIFO pointers and occupancy;
  // the word read at the accept edge is pushed at the following edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_q      <= 1'b0;
      hold_q   <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      f_q <= is_read;
      if (is_read) begin
        hold_q <= pkt_in;
      end
      if (push) begin
        wr_ptr_q <= ptr_next(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_next(rd_ptr_q);
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (pop && !push) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // FIFO storage needs no reset because the outputs are gated by occupancy
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pkt[wr_ptr_q]  <= hold_q;
      fifo_inst[wr_ptr_q] <= pm_rdata;
    end
  end

  // Head entry drives the outputs, forced to zero while the FIFO is empty
  always_comb begin
    head_pkt = '0;
    inst_o   = '0;
    if (send_o) begin
      head_pkt = fifo_pkt[rd_ptr_q];
      inst_o   = fifo_inst[rd_ptr_q];
    end
  end

  assign node_o     = head_pkt.node;
  assign gen_o      = head_pkt.gen;
  assign opr0_o     = head_pkt.opr0;
  assign opr1_o     = head_pkt.opr1;
  assign mem_wen1_o = head_pkt.mem_wen1;
  assign w_en_cex_o = head_pkt.w_en_cex;

  // The reserved slot must always be there when the in-flight read lands
  a_no_push_when_full : assert property (
    @(posedge clk) disable iff (!rst) !(push && (int'(cnt_q) >= OBUF_DEPTH))
  );

`ifdef FTC1_PERF_CNT_EN
  logic [15:0] perf_fwd_q;
  logic [15:0] perf_stall_q;

  // Saturating counts of packets handed downstream and of refused upstream cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fwd_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (pop && (perf_fwd_q != 16'hFFFF)) begin
        perf_fwd_q <= perf_fwd_q + 16'd1;
      end
      if (send_i && !ack_o && (perf_stall_q != 16'hFFFF)) begin
        perf_stall_q <= perf_stall_q + 16'd1;
      end
    end
  end

  assign perf_fwd_o   = perf_fwd_q;
  assign perf_stall_o = perf_stall_q;
`endif

endmodule
